shift_register_universal: RTL and testbench
===========================================

// Module: shift_register_universal
//
// PURPOSE
//   Parametrised universal shift register for serial links and bit-bang
//   interfaces.
//   - Right-shift mode is bit-compatible with the team's 1-bit serial-in
//     shift register: new bit enters at MSB.
//   - Adds left shift, rotate, parallel load and synchronous clear.
//   - A shift counter marks each completed W-bit word, so the block can act
//     as a deserialiser (serial in, word out) or a serialiser (load, shift out).
//
// PARAMETERS
//   W     8   register width in bits; legal range 2..64
//   CW    derived localparam = $clog2(W); counter width (1 when W=2)
//
// PORTS
//   clk         in   1   clock, rising edge
//   reset       in   1   asynchronous, active-high; clears all state
//   sclr        in   1   synchronous clear; highest priority after reset
//   en          in   1   clock enable; en=0 holds all state
//   mode        in   2   00 hold, 01 shift right, 10 shift left, 11 load
//   rotate      in   1   1: re-inject the bit shifted out instead of sin
//   sin         in   1   serial input
//   pin         in   W   parallel load data
//   pout        out  W   register contents (registered)
//   sout        out  1   bit leaving on the next shift (combinational from pout, mode)
//   count       out  CW  shifts taken since last word boundary or load
//   word_valid  out  1   one-cycle pulse: W shifts completed, pout holds full word
//
// BEHAVIOUR
//   - Reset: pout=0, count=0, word_valid=0; sout follows pout, so sout=0.
//   - Priority, per clock edge:
//       reset > sclr > en=0 > mode.
//       sclr: same values as reset. en=0: everything holds, word_valid -> 0.
//   - Shift right (01):
//       pout <= {b, pout[W-1:1]}, with b = rotate ? pout[0] : sin.
//   - Shift left (10):
//       pout <= {pout[W-2:0], b}, with b = rotate ? pout[W-1] : sin.
//   - Load (11): pout <= pin; count <= 0; word_valid <= 0.
//   - Hold (00): pout and count hold; word_valid <= 0.
//   - sout: pout[0] when mode=01; pout[W-1] when mode=10; 0 otherwise.
//   - Counter (shift modes only, en=1):
//       count <  W-1: count <= count+1, word_valid <= 0.
//       count == W-1: count <= 0, word_valid <= 1.
//     word_valid is high in the cycle after the W-th shift, in the same
//     cycle pout shows the completed word.
//   - Back-to-back words: continuous shifting gives one word_valid every W
//     cycles; there are no gaps.
//   - Direction change mid-word: count keeps running; no error is flagged.
//   - Rotate mode still counts: W rotates restore the original pout and
//     pulse word_valid.
//   - Reset or sclr mid-word: the partial word is discarded and no
//     word_valid is issued.
//   - Latency: one clock from shift/load edge to pout; no combinational
//     path from sin or pin to pout.
//
// TESTING
//   1. Reset with W=8, pout preloaded 0xA5 -> pout=0x00, count=0,
//      word_valid=0 immediately, without waiting for a clock edge.
//   2. mode=01, sin=1,0,1,1,0,0,1,0 on 8 enabled cycles
//      -> pout=0x4D; word_valid high exactly one cycle, after the 8th edge.
//   3. Load pin=0x81, then mode=10, rotate=1, 8 shifts
//      -> sout sequence 1,0,0,0,0,0,0,1; pout returns to 0x81;
//         one word_valid pulse.
//   4. 3 right shifts, then en=0 for 5 cycles, then 5 more shifts
//      -> count holds at 3 during the stall; word_valid only after the
//         8th shift.
//   5. 5 shifts, then sclr=1 together with mode=01 -> pout=0, count=0;
//      the next 8 shifts produce exactly one word_valid.
//   6. W=2 build: 6 continuous shifts -> word_valid on cycles 2, 4 and 6;
//      mode=00 -> pout unchanged.

Source files
------------

// File: rtl/shift_register_universal.sv
// Universal W-bit shift register: shift right/left with optional rotate, parallel load,
// synchronous clear, and a shift counter that pulses word_valid on every completed W-bit word.
module shift_register_universal #(
  parameter int W = 8,
  localparam int CW = (W > 2) ? $clog2(W) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sclr,
  input  logic          en,
  input  logic [1:0]    mode,
  input  logic          rotate,
  input  logic          sin,
  input  logic [W-1:0]  pin,
  output logic [W-1:0]  pout,
  output logic          sout,
  output logic [CW-1:0] count,
  output logic          word_valid
);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  localparam logic [CW-1:0] COUNT_LAST = CW'(W - 1);

  logic [W-1:0]  pout_q, pout_d;
  logic [CW-1:0] count_q, count_d;
  logic          word_valid_q, word_valid_d;
  logic          right_in;
  logic          left_in;
  logic          shifting;

  // In rotate mode the bit leaving one end re-enters at the other.
  assign right_in = rotate ? pout_q[0]   : sin;
  assign left_in  = rotate ? pout_q[W-1] : sin;
  assign shifting = (mode == MODE_RIGHT) || (mode == MODE_LEFT);

  always_comb begin
    pout_d       = pout_q;
    count_d      = count_q;
    word_valid_d = 1'b0;
    if (sclr) begin
      pout_d  = '0;
      count_d = '0;
    end else if (en) begin
      case (mode)
        MODE_RIGHT: pout_d = {right_in, pout_q[W-1:1]};
        MODE_LEFT:  pout_d = {pout_q[W-2:0], left_in};
        MODE_LOAD: begin
          pout_d  = pin;
          count_d = '0;
        end
        default:    pout_d = pout_q;
      endcase
      // Counter runs across direction changes; it wraps on the W-th shift.
      if (shifting) begin
        if (count_q == COUNT_LAST) begin
          count_d      = '0;
          word_valid_d = 1'b1;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pout_q       <= '0;
      count_q      <= '0;
      word_valid_q <= 1'b0;
    end else begin
      pout_q       <= pout_d;
      count_q      <= count_d;
      word_valid_q <= word_valid_d;
    end
  end

  always_comb begin
    case (mode)
      MODE_RIGHT: sout = pout_q[0];
      MODE_LEFT:  sout = pout_q[W-1];
      default:    sout = 1'b0;
    endcase
  end

  assign pout       = pout_q;
  assign count      = count_q;
  assign word_valid = word_valid_q;

endmodule

// File: tb/tb_shift_register_universal.sv
// Directed, table-driven bench for shift_register_universal: a W=8 instance runs the
// vector table, a W=2 instance covers the narrowest build.
module tb_shift_register_universal;

  typedef struct {
    logic       sclr;
    logic       en;
    logic [1:0] mode;
    logic       rotate;
    logic       sin;
    logic [7:0] pin;
    logic       exp_sout;   // checked before the edge
    logic [7:0] exp_pout;   // checked after the edge
    logic [2:0] exp_count;
    logic       exp_wv;
  } vec_t;

  logic       clk;
  logic       reset;
  logic       sclr, en, rotate, sin;
  logic [1:0] mode;
  logic [7:0] pin;
  logic [7:0] pout;
  logic       sout;
  logic [2:0] count;
  logic       word_valid;

  logic       sclr2, en2, rotate2, sin2;
  logic [1:0] mode2;
  logic [1:0] pin2;
  logic [1:0] pout2;
  logic       sout2;
  logic [0:0] count2;
  logic       word_valid2;

  int n_checks;
  int n_fail;
  vec_t vecs[$];

  shift_register_universal #(.W(8)) u_dut (
    .clk(clk), .reset(reset), .sclr(sclr), .en(en), .mode(mode), .rotate(rotate),
    .sin(sin), .pin(pin), .pout(pout), .sout(sout), .count(count), .word_valid(word_valid)
  );

  shift_register_universal #(.W(2)) u_dut_w2 (
    .clk(clk), .reset(reset), .sclr(sclr2), .en(en2), .mode(mode2), .rotate(rotate2),
    .sin(sin2), .pin(pin2), .pout(pout2), .sout(sout2), .count(count2),
    .word_valid(word_valid2)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic s, input logic e, input logic [1:0] m,
                              input logic r, input logic si, input logic [7:0] p,
                              input logic eso, input logic [7:0] ep,
                              input logic [2:0] ec, input logic ew);
    vec_t v;
    v.sclr = s; v.en = e; v.mode = m; v.rotate = r; v.sin = si; v.pin = p;
    v.exp_sout = eso; v.exp_pout = ep; v.exp_count = ec; v.exp_wv = ew;
    return v;
  endfunction

  task automatic drive(input logic s, input logic e, input logic [1:0] m,
                       input logic r, input logic si, input logic [7:0] p);
    sclr = s; en = e; mode = m; rotate = r; sin = si; pin = p;
  endtask

  task automatic apply_vec(input int idx, input vec_t v);
    drive(v.sclr, v.en, v.mode, v.rotate, v.sin, v.pin);
    #1;
    check($sformatf("v%0d sout", idx), 64'(sout), 64'(v.exp_sout));
    @(posedge clk);
    #1;
    check($sformatf("v%0d pout", idx), 64'(pout), 64'(v.exp_pout));
    check($sformatf("v%0d count", idx), 64'(count), 64'(v.exp_count));
    check($sformatf("v%0d word_valid", idx), 64'(word_valid), 64'(v.exp_wv));
  endtask

  initial begin
    logic       w2_sin[6];
    logic [1:0] w2_pout[6];
    logic       w2_cnt[6];
    logic       w2_wv[6];

    n_checks = 0;
    n_fail   = 0;
    drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00);
    sclr2 = 1'b0; en2 = 1'b0; mode2 = 2'b00; rotate2 = 1'b0; sin2 = 1'b0; pin2 = 2'b00;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Async reset with a loaded value: clears without a clock edge
    drive(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 8'hA5);
    @(posedge clk);
    #1;
    check("preload pout", 64'(pout), 64'hA5);
    drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00);
    #2 reset = 1'b1;
    #1;
    check("async reset pout", 64'(pout), 64'h00);
    check("async reset count", 64'(count), 64'h0);
    check("async reset word_valid", 64'(word_valid), 64'h0);
    check("async reset sout", 64'(sout), 64'h0);
    @(posedge clk);
    #1 reset = 1'b0;

    // {sclr, en, mode, rotate, sin, pin, exp_sout(pre), exp_pout, exp_count, exp_wv}
    // Deserialise 1,0,1,1,0,0,1,0 via shift right
    vecs.push_back(mk(0, 1, 2'b01, 0, 1, 8'h00, 0, 8'h80, 3'd1, 0));
    vecs.push_back(mk(0, 1, 2'b01, 0, 0, 8'h00, 0, 8'h40, 3'd2, 0));
    vecs.push_back(mk(0, 1, 2'b01, 0, 1, 8'h00, 0, 8'hA0, 3'd3, 0));
    vecs.push_back(mk(0, 1, 2'b01, 0, 1, 8'h00, 0, 8'hD0, 3'd4, 0));
    vecs.push_back(mk(0, 1, 2'b01, 0, 0, 8'h00, 0, 8'h68, 3'd5, 0));
    vecs.push_back(mk(0, 1, 2'b01, 0, 0, 8'h00, 0, 8'h34, 3'd6, 0));
    vecs.push_back(mk(0, 1, 2'b01, 0, 1, 8'h00, 0, 8'h9A, 3'd7, 0));
    vecs.push_back(mk(0, 1, 2'b01, 0, 0, 8'h00, 0, 8'h4D, 3'd0, 1));
    vecs.push_back(mk(0, 1, 2'b00, 0, 1, 8'h00, 0, 8'h4D, 3'd0, 0));
    // Load 0x81 then rotate left 8 times: sout 1,0,0,0,0,0,0,1
    vecs.push_back(mk(0, 1, 2'b11, 0, 0, 8'h81, 0, 8'h81, 3'd0, 0));
    vecs.push_back(mk(0, 1, 2'b10, 1, 0, 8'h00, 1, 8'h03, 3'd1, 0));
    vecs.push_back(mk(0, 1, 2'b10, 1, 0, 8'h00, 0, 8'h06, 3'd2, 0));
    vecs.push_back(mk(0, 1, 2'b10, 1, 0, 8'h00, 0, 8'h0C, 3'd3, 0));
    vecs.push_back(mk(0, 1, 2'b10, 1, 0, 8'h00, 0, 8'h18, 3'd4, 0));
    vecs.push_back(mk(0, 1, 2'b10, 1, 0, 8'h00, 0, 8'h30, 3'd5, 0));
    vecs.push_back(mk(0, 1, 2'b10, 1, 0, 8'h00, 0, 8'h60, 3'd6, 0));
    vecs.push_back(mk(0, 1, 2'b10, 1, 0, 8'h00, 0, 8'hC0, 3'd7, 0));
    vecs.push_back(mk(0, 1, 2'b10, 1, 0, 8'h00, 1, 8'h81, 3'd0, 1));
    // 3 shifts, 5-cycle stall, 5 shifts
    vecs.push_back(mk(0, 1, 2'b01, 0, 1, 8'h00, 1, 8'hC0, 3'd1, 0));
    vecs.push_back(mk(0, 1, 2'b01, 0, 1, 8'h00, 0, 8'hE0, 3'd2, 0));
    vecs.push_back(mk(0, 1, 2'b01, 0, 1, 8'h00, 0, 8'hF0, 3'd3, 0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 0, 2'b01, 0, 0, 8'h00, 0, 8'hF0, 3'd3, 0));
    vecs.push_back(mk(0, 1, 2'b01, 0, 0, 8'h00, 0, 8'h78, 3'd4, 0));
    vecs.push_back(mk(0, 1, 2'b01, 0, 0, 8'h00, 0, 8'h3C, 3'd5, 0));
    vecs.push_back(mk(0, 1, 2'b01, 0, 0, 8'h00, 0, 8'h1E, 3'd6, 0));
    vecs.push_back(mk(0, 1, 2'b01, 0, 0, 8'h00, 0, 8'h0F, 3'd7, 0));
    vecs.push_back(mk(0, 1, 2'b01, 0, 0, 8'h00, 1, 8'h07, 3'd0, 1));
    vecs.push_back(mk(0, 0, 2'b01, 0, 0, 8'h00, 1, 8'h07, 3'd0, 0));
    // 5 shifts, sclr with mode=01, then a full word of ones
    vecs.push_back(mk(0, 1, 2'b01, 0, 1, 8'h00, 1, 8'h83, 3'd1, 0));
    vecs.push_back(mk(0, 1, 2'b01, 0, 1, 8'h00, 1, 8'hC1, 3'd2, 0));
    vecs.push_back(mk(0, 1, 2'b01, 0, 1, 8'h00, 1, 8'hE0, 3'd3, 0));
    vecs.push_back(mk(0, 1, 2'b01, 0, 1, 8'h00, 0, 8'hF0, 3'd4, 0));
    vecs.push_back(mk(0, 1, 2'b01, 0, 1, 8'h00, 0, 8'hF8, 3'd5, 0));
    vecs.push_back(mk(1, 1, 2'b01, 0, 1, 8'h00, 0, 8'h00, 3'd0, 0));
    vecs.push_back(mk(0, 1, 2'b01, 0, 1, 8'h00, 0, 8'h80, 3'd1, 0));
    vecs.push_back(mk(0, 1, 2'b01, 0, 1, 8'h00, 0, 8'hC0, 3'd2, 0));
    vecs.push_back(mk(0, 1, 2'b01, 0, 1, 8'h00, 0, 8'hE0, 3'd3, 0));
    vecs.push_back(mk(0, 1, 2'b01, 0, 1, 8'h00, 0, 8'hF0, 3'd4, 0));
    vecs.push_back(mk(0, 1, 2'b01, 0, 1, 8'h00, 0, 8'hF8, 3'd5, 0));
    vecs.push_back(mk(0, 1, 2'b01, 0, 1, 8'h00, 0, 8'hFC, 3'd6, 0));
    vecs.push_back(mk(0, 1, 2'b01, 0, 1, 8'h00, 0, 8'hFE, 3'd7, 0));
    vecs.push_back(mk(0, 1, 2'b01, 0, 1, 8'h00, 0, 8'hFF, 3'd0, 1));
    // sclr beats en=0; then left shift with sin
    vecs.push_back(mk(1, 0, 2'b10, 0, 1, 8'h00, 1, 8'h00, 3'd0, 0));
    vecs.push_back(mk(0, 1, 2'b10, 0, 1, 8'h00, 0, 8'h01, 3'd1, 0));
    // Direction change mid-word keeps counting
    vecs.push_back(mk(0, 1, 2'b01, 0, 0, 8'h00, 1, 8'h00, 3'd2, 0));

    for (int i = 0; i < vecs.size(); i++) apply_vec(i, vecs[i]);

    // Async reset mid-word discards the partial word
    drive(1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 8'h00);
    @(posedge clk);
    #1;
    check("midword pre-reset count", 64'(count), 64'h3);
    #1 reset = 1'b1;
    #1;
    check("midword reset pout", 64'(pout), 64'h00);
    check("midword reset count", 64'(count), 64'h0);
    drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00);
    @(posedge clk);
    #1 reset = 1'b0;

    // W=2 build: continuous shifts, word_valid every second cycle
    w2_sin  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    w2_pout = '{2'b10, 2'b11, 2'b01, 2'b10, 2'b11, 2'b01};
    w2_cnt  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    w2_wv   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    en2 = 1'b1; mode2 = 2'b01;
    for (int i = 0; i < 6; i++) begin
      sin2 = w2_sin[i];
      @(posedge clk);
      #1;
      check($sformatf("w2 c%0d pout", i + 1), 64'(pout2), 64'(w2_pout[i]));
      check($sformatf("w2 c%0d count", i + 1), 64'(count2), 64'(w2_cnt[i]));
      check($sformatf("w2 c%0d word_valid", i + 1), 64'(word_valid2), 64'(w2_wv[i]));
    end
    mode2 = 2'b00; sin2 = 1'b1;
    @(posedge clk);
    #1;
    check("w2 hold pout", 64'(pout2), 64'h1);
    check("w2 hold word_valid", 64'(word_valid2), 64'h0);
    check("w2 hold sout", 64'(sout2), 64'h0);
    mode2 = 2'b10;
    #1;
    check("w2 left sout", 64'(sout2), 64'h0);
    mode2 = 2'b01;
    #1;
    check("w2 right sout", 64'(sout2), 64'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
